// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the DataMemory arbiter: FSM encoding, requester ids,
// and the alignment helper.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } arbState_t;

  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, and on contention the one
// that did not win last time gets the grant.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic       winner,
  output logic       anyReq
);

  always_comb begin
    anyReq = |req;
    winner = REQ_R0;
    case (req)
      2'b01:   winner = REQ_R0;
      2'b10:   winner = REQ_R1;
      2'b11:   winner = (lastGrant == REQ_R0) ? REQ_R1 : REQ_R0;
      default: winner = REQ_R0;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port DataMemory between the pipeline MEM stage (R0) and a
// debug/DMA port (R1), one word per grant, with a registered ack back to the winner.
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,

  input  logic              R0_Req,
  input  logic              R0_Wr,
  input  logic [ADDR_W-1:0] R0_Addr,
  input  logic [DATA_W-1:0] R0_WData,
  output logic              R0_Ack,
  output logic              R0_Err,
  output logic [DATA_W-1:0] R0_RData,

  input  logic              R1_Req,
  input  logic              R1_Wr,
  input  logic [ADDR_W-1:0] R1_Addr,
  input  logic [DATA_W-1:0] R1_WData,
  output logic              R1_Ack,
  output logic              R1_Err,
  output logic [DATA_W-1:0] R1_RData,

  output logic              Busy,

  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WriteData,
  output logic              Mem_MemWrite,
  output logic              Mem_MemRead,
  input  logic [DATA_W-1:0] Mem_ReadData
);

  arbState_t         state;
  logic              lastGrant;
  logic              latchedId;
  logic              latchedWr;
  logic              latchedErr;
  logic [ADDR_W-1:0] latchedAddr;
  logic [DATA_W-1:0] latchedWData;

  logic              winner;
  logic              anyReq;
  logic              selWr;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWData;
  logic              readOk;

  rr_arbiter2 uArb (
    .req       ({R1_Req, R0_Req}),
    .lastGrant (lastGrant),
    .winner    (winner),
    .anyReq    (anyReq)
  );

  always_comb begin
    selWr    = (winner == REQ_R1) ? R1_Wr    : R0_Wr;
    selAddr  = (winner == REQ_R1) ? R1_Addr  : R0_Addr;
    selWData = (winner == REQ_R1) ? R1_WData : R0_WData;
  end

  assign readOk = ~latchedWr & ~latchedErr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      lastGrant    <= REQ_R1;
      latchedId    <= REQ_R0;
      latchedWr    <= 1'b0;
      latchedErr   <= 1'b0;
      latchedAddr  <= '0;
      latchedWData <= '0;
      R0_Ack       <= 1'b0;
      R0_Err       <= 1'b0;
      R0_RData     <= '0;
      R1_Ack       <= 1'b0;
      R1_Err       <= 1'b0;
      R1_RData     <= '0;
    end else begin
      case (state)
        IDLE: begin
          R0_Ack   <= 1'b0;
          R0_Err   <= 1'b0;
          R0_RData <= '0;
          R1_Ack   <= 1'b0;
          R1_Err   <= 1'b0;
          R1_RData <= '0;
          if (anyReq) begin
            latchedId    <= winner;
            latchedWr    <= selWr;
            latchedAddr  <= selAddr;
            latchedWData <= selWData;
            latchedErr   <= isMisaligned(selAddr[1:0]);
            lastGrant    <= winner;
            state        <= ACCESS;
          end
        end
        // Read data is sampled here, at the same edge that commits a write.
        ACCESS: begin
          R0_Ack   <= (latchedId == REQ_R0);
          R0_Err   <= (latchedId == REQ_R0) & latchedErr;
          R0_RData <= ((latchedId == REQ_R0) && readOk) ? Mem_ReadData : '0;
          R1_Ack   <= (latchedId == REQ_R1);
          R1_Err   <= (latchedId == REQ_R1) & latchedErr;
          R1_RData <= ((latchedId == REQ_R1) && readOk) ? Mem_ReadData : '0;
          state    <= DONE;
        end
        DONE: begin
          R0_Ack   <= 1'b0;
          R0_Err   <= 1'b0;
          R0_RData <= '0;
          R1_Ack   <= 1'b0;
          R1_Err   <= 1'b0;
          R1_RData <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by Reset combinationally so a reset during ACCESS never commits a write.
  assign Busy          = (state != IDLE);
  assign Mem_Address   = latchedAddr;
  assign Mem_WriteData = latchedWData;
  assign Mem_MemWrite  = (state == ACCESS) & latchedWr & ~latchedErr & ~Reset;
  assign Mem_MemRead   = (state == ACCESS) & ~latchedWr & ~latchedErr & ~Reset;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter with a behavioural word-addressed DataMemory;
// expected acks are queued on a scoreboard when stimulus is driven.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

  logic        Clk;
  logic        Reset;
  logic        R0_Req, R0_Wr, R1_Req, R1_Wr;
  logic [31:0] R0_Addr, R0_WData, R1_Addr, R1_WData;
  logic        R0_Ack, R0_Err, R1_Ack, R1_Err;
  logic [31:0] R0_RData, R1_RData;
  logic        Busy;
  logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic        Mem_MemWrite, Mem_MemRead;

  logic [31:0] mem [0:255];

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] data;
  } expT;

  typedef struct {
    logic        got;
    logic        id;
    logic        err;
    logic [31:0] data;
    int          cycles;
    logic        other;
    logic        memTouch;
  } obsT;

  expT expQ[$];
  int  checkCount = 0;
  int  passCount  = 0;

  data_memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .R0_Req        (R0_Req),
    .R0_Wr         (R0_Wr),
    .R0_Addr       (R0_Addr),
    .R0_WData      (R0_WData),
    .R0_Ack        (R0_Ack),
    .R0_Err        (R0_Err),
    .R0_RData      (R0_RData),
    .R1_Req        (R1_Req),
    .R1_Wr         (R1_Wr),
    .R1_Addr       (R1_Addr),
    .R1_WData      (R1_WData),
    .R1_Ack        (R1_Ack),
    .R1_Err        (R1_Err),
    .R1_RData      (R1_RData),
    .Busy          (Busy),
    .Mem_Address   (Mem_Address),
    .Mem_WriteData (Mem_WriteData),
    .Mem_MemWrite  (Mem_MemWrite),
    .Mem_MemRead   (Mem_MemRead),
    .Mem_ReadData  (Mem_ReadData)
  );

  initial Clk = 1'b0;
  always #100 Clk = ~Clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end
  always @(posedge Clk) if (Mem_MemWrite) mem[Mem_Address[9:2]] <= Mem_WriteData;
  assign Mem_ReadData = mem[Mem_Address[9:2]];

  task automatic applyStimulus(input logic id, input logic req, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (id) begin
      R1_Req = req; R1_Wr = wr; R1_Addr = addr; R1_WData = wdata;
    end else begin
      R0_Req = req; R0_Wr = wr; R0_Addr = addr; R0_WData = wdata;
    end
  endtask

  task automatic pushExp(input logic id, input logic err, input logic [31:0] data);
    expT e;
    e.id = id; e.err = err; e.data = data;
    expQ.push_back(e);
  endtask

  task automatic popExp(output expT e);
    if (expQ.size() > 0) e = expQ.pop_front();
    else begin e.id = 1'bx; e.err = 1'bx; e.data = 'x; end
  endtask

  // Watches negedges until either requester is acked or the budget runs out.
  task automatic observeAck(input int budget, output obsT o);
    o.got = 0; o.id = 0; o.err = 0; o.data = 0; o.cycles = 0; o.other = 0; o.memTouch = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      o.cycles++;
      if (Mem_MemRead || Mem_MemWrite) o.memTouch = 1;
      if (R0_Ack || R1_Ack) begin
        o.got   = 1;
        o.id    = R1_Ack;
        o.err   = R1_Ack ? R1_Err : R0_Err;
        o.data  = R1_Ack ? R1_RData : R0_RData;
        o.other = R1_Ack ? (R0_Ack | R0_Err | (|R0_RData)) : (R1_Err | (|R1_RData));
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkCount++;
    if ({R0_Ack, R0_Err, R1_Ack, R1_Err, Busy, Mem_MemWrite, Mem_MemRead} !== 7'b0)
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {R0_Ack, R0_Err, R1_Ack, R1_Err, Busy, Mem_MemWrite, Mem_MemRead});
    else passCount++;
    checkCount++;
    if ({R0_RData, R1_RData, Mem_Address} !== 96'h0)
      $display("[TB] FAIL reset_regs: got %h %h %h expected zeros", R0_RData, R1_RData, Mem_Address);
    else passCount++;
    Reset = 1'b0;
    @(negedge Clk);
    checkCount++;
    if ({Busy, R0_Ack, R1_Ack} !== 3'b0)
      $display("[TB] FAIL post_reset_idle: got %b expected 000", {Busy, R0_Ack, R1_Ack});
    else passCount++;
  endtask

  task automatic test_write_read;
    obsT o;
    expT e;
    applyStimulus(0, 1, 1, 32'h10, 32'hDEADBEEF);
    pushExp(0, 0, 32'h0);
    observeAck(8, o);
    popExp(e);
    checkCount++;
    if ({o.got, o.id, o.err, o.data, o.other} !== {1'b1, e.id, e.err, e.data, 1'b0})
      $display("[TB] FAIL r0_write_ack: got %b/%b/%b/%h expected 1/%b/%b/%h",
               o.got, o.id, o.err, o.data, e.id, e.err, e.data);
    else passCount++;
    checkCount++;
    if (o.cycles !== 2) $display("[TB] FAIL r0_write_latency: got %0d expected 2", o.cycles);
    else passCount++;
    applyStimulus(0, 1, 0, 32'h10, 32'h0);
    pushExp(0, 0, 32'hDEADBEEF);
    observeAck(8, o);
    popExp(e);
    applyStimulus(0, 0, 0, 0, 0);
    checkCount++;
    if ({o.got, o.id, o.err, o.data, o.other} !== {1'b1, e.id, e.err, e.data, 1'b0})
      $display("[TB] FAIL r0_read_ack: got %b/%b/%b/%h expected 1/%b/%b/%h",
               o.got, o.id, o.err, o.data, e.id, e.err, e.data);
    else passCount++;
    checkCount++;
    if (o.cycles !== 3) $display("[TB] FAIL r0_read_b2b_latency: got %0d expected 3", o.cycles);
    else passCount++;
  endtask

  task automatic test_contention;
    obsT o;
    expT e;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(0, 1, 0, 32'h10, 32'h0);
    applyStimulus(1, 1, 0, 32'h44, 32'h0);
    for (int i = 0; i < 6; i++) pushExp(i[0], 0, i[0] ? 32'h0 : 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      observeAck(8, o);
      popExp(e);
      checkCount++;
      if ({o.got, o.id, o.err, o.data, o.other} !== {1'b1, e.id, e.err, e.data, 1'b0})
        $display("[TB] FAIL contention_grant%0d: got %b/%b/%b/%h expected 1/%b/%b/%h",
                 i, o.got, o.id, o.err, o.data, e.id, e.err, e.data);
      else passCount++;
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge Clk);
  endtask

  task automatic test_misaligned;
    obsT o;
    expT e;
    applyStimulus(1, 1, 0, 32'h13, 32'h0);
    pushExp(1, 1, 32'h0);
    observeAck(8, o);
    popExp(e);
    applyStimulus(1, 0, 0, 0, 0);
    checkCount++;
    if ({o.got, o.id, o.err, o.data, o.other} !== {1'b1, e.id, e.err, e.data, 1'b0})
      $display("[TB] FAIL r1_misaligned_ack: got %b/%b/%b/%h expected 1/%b/%b/%h",
               o.got, o.id, o.err, o.data, e.id, e.err, e.data);
    else passCount++;
    checkCount++;
    if (o.memTouch !== 1'b0) $display("[TB] FAIL r1_misaligned_mem_strobe: got %b expected 0", o.memTouch);
    else passCount++;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_access;
    obsT o;
    expT e;
    applyStimulus(0, 1, 1, 32'h20, 32'h12345678);
    @(negedge Clk);
    checkCount++;
    if ({Busy, Mem_MemWrite} !== 2'b11) $display("[TB] FAIL access_write_strobe: got %b expected 11", {Busy, Mem_MemWrite});
    else passCount++;
    Reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkCount++;
    if (Mem_MemWrite !== 1'b0) $display("[TB] FAIL reset_gates_write: got %b expected 0", Mem_MemWrite);
    else passCount++;
    @(negedge Clk);
    Reset = 1'b0;
    checkCount++;
    if ({Busy, R0_Ack} !== 2'b00) $display("[TB] FAIL after_reset_edge: got %b expected 00", {Busy, R0_Ack});
    else passCount++;
    observeAck(5, o);
    checkCount++;
    if (o.got !== 1'b0) $display("[TB] FAIL lost_txn_no_ack: got %b expected 0", o.got);
    else passCount++;
    checkCount++;
    if (mem[8] !== 32'h0) $display("[TB] FAIL no_commit_0x20: got %h expected 00000000", mem[8]);
    else passCount++;
    applyStimulus(0, 1, 0, 32'h20, 32'h0);
    pushExp(0, 0, 32'h0);
    observeAck(8, o);
    popExp(e);
    applyStimulus(0, 0, 0, 0, 0);
    checkCount++;
    if ({o.got, o.id, o.err, o.data} !== {1'b1, e.id, e.err, e.data})
      $display("[TB] FAIL read_after_lost_write: got %b/%b/%b/%h expected 1/%b/%b/%h",
               o.got, o.id, o.err, o.data, e.id, e.err, e.data);
    else passCount++;
    @(negedge Clk);
  endtask

  task automatic test_coherency;
    obsT o;
    expT e;
    applyStimulus(1, 1, 1, 32'h40, 32'hA5A5A5A5);
    pushExp(1, 0, 32'h0);
    observeAck(8, o);
    popExp(e);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h40, 32'h0);
    checkCount++;
    if ({o.got, o.id, o.err, o.data, o.other} !== {1'b1, e.id, e.err, e.data, 1'b0})
      $display("[TB] FAIL r1_write_ack: got %b/%b/%b/%h expected 1/%b/%b/%h",
               o.got, o.id, o.err, o.data, e.id, e.err, e.data);
    else passCount++;
    pushExp(0, 0, 32'hA5A5A5A5);
    observeAck(8, o);
    popExp(e);
    applyStimulus(0, 0, 0, 0, 0);
    checkCount++;
    if ({o.got, o.id, o.err, o.data, o.other} !== {1'b1, e.id, e.err, e.data, 1'b0})
      $display("[TB] FAIL r0_reads_r1_data: got %b/%b/%b/%h expected 1/%b/%b/%h",
               o.got, o.id, o.err, o.data, e.id, e.err, e.data);
    else passCount++;
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_misaligned();
    test_reset_mid_access();
    test_coherency();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
